serial_alu_w_flag: RTL and testbench



---
 rtl/serial_alu_w_flag_if.sv | 28 ++
 rtl/serial_alu_w_flag.sv | 155 +++++++++++++++
 tb/tb_serial_alu_w_flag.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_alu_w_flag_if.sv
// Valid/ready bundle between the execute-stage pipeline and the serial ALU.
// master drives operands and consumes results; slave is the ALU.
interface serial_alu_w_flag_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input_A;
  logic [WIDTH-1:0] input_B;
  logic [2:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, input_A, input_B, control, out_ready,
    input  in_ready, out_valid, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  in_valid, input_A, input_B, control, out_ready,
    output in_ready, out_valid, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/serial_alu_w_flag.sv
// Multi-cycle ALU: SLICE bits per clock, LSB slice first, with N/Z/V/C flags.
// One operation in flight; the result is held until the consumer takes it.
module serial_alu_w_flag #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 1
) (
  input logic                clk,
  input logic                reset_n,
  serial_alu_w_flag_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   a_q, a_n, b_q, b_n, res_q, res_n;
  logic [2:0]         ctrl_q, ctrl_n;
  logic               carry_q, carry_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               zacc_q, zacc_n;
  logic               neg_q, neg_n, zero_q, zero_n, ovf_q, ovf_n, cout_q, cout_n;
  logic               in_ready_q, in_ready_n, out_valid_q, out_valid_n;

  logic [SLICE-1:0]   a_s, b_eff, sum_s, slice_res;
  logic               carry_chain, carry_msb_in, is_arith;
  logic [WIDTH+SLICE-1:0] shifted;

  // Slice datapath: ripple adder plus the bitwise ops on the low SLICE bits
  always_comb begin
    a_s          = a_q[SLICE-1:0];
    b_eff        = (ctrl_q == OP_SUB) ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
    carry_chain  = carry_q;
    carry_msb_in = 1'b0;
    sum_s        = '0;
    for (int i = 0; i < int'(SLICE); i++) begin
      carry_msb_in = carry_chain;
      sum_s[i]     = a_s[i] ^ b_eff[i] ^ carry_chain;
      carry_chain  = (a_s[i] & b_eff[i]) | (carry_chain & (a_s[i] ^ b_eff[i]));
    end
    is_arith = (ctrl_q == OP_ADD) || (ctrl_q == OP_SUB);
    case (ctrl_q)
      OP_PASS_B:      slice_res = b_q[SLICE-1:0];
      OP_ADD, OP_SUB: slice_res = sum_s;
      OP_AND:         slice_res = a_s & b_q[SLICE-1:0];
      OP_OR:          slice_res = a_s | b_q[SLICE-1:0];
      OP_XOR:         slice_res = a_s ^ b_q[SLICE-1:0];
      default:        slice_res = '0;
    endcase
  end

  // Next-state and register updates
  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    res_n   = res_q;
    ctrl_n  = ctrl_q;
    carry_n = carry_q;
    cnt_n   = cnt_q;
    zacc_n  = zacc_q;
    neg_n   = neg_q;
    zero_n  = zero_q;
    ovf_n   = ovf_q;
    cout_n  = cout_q;
    shifted = {slice_res, res_q};

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_n     = bus.input_A;
          b_n     = bus.input_B;
          ctrl_n  = bus.control;
          carry_n = (bus.control == OP_SUB);
          cnt_n   = '0;
          zacc_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        a_n     = a_q >> SLICE;
        b_n     = b_q >> SLICE;
        res_n   = shifted[WIDTH+SLICE-1:SLICE];
        carry_n = carry_chain;
        zacc_n  = zacc_q & (slice_res == '0);
        cnt_n   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NSLICE - 1)) begin
          neg_n   = slice_res[SLICE-1];
          zero_n  = zacc_q & (slice_res == '0);
          cout_n  = is_arith & carry_chain;
          ovf_n   = is_arith & (carry_msb_in ^ carry_chain);
          state_n = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      ctrl_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      zacc_q      <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      a_q         <= a_n;
      b_q         <= b_n;
      res_q       <= res_n;
      ctrl_q      <= ctrl_n;
      carry_q     <= carry_n;
      cnt_q       <= cnt_n;
      zacc_q      <= zacc_n;
      neg_q       <= neg_n;
      zero_q      <= zero_n;
      ovf_q       <= ovf_n;
      cout_q      <= cout_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_alu_w_flag.sv
// Directed bench for serial_alu_w_flag: an 8-bit/1-bit-slice instance and a
// 64-bit/4-bit-slice instance sharing one clock and reset.
module tb_serial_alu_w_flag;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_alu_w_flag_if #(.WIDTH(8))  b8 ();
  serial_alu_w_flag_if #(.WIDTH(64)) b64 ();

  serial_alu_w_flag #(.WIDTH(8), .SLICE(1)) u8 (
    .clk(clk), .reset_n(reset_n), .bus(b8)
  );
  serial_alu_w_flag #(.WIDTH(64), .SLICE(4)) u64 (
    .clk(clk), .reset_n(reset_n), .bus(b64)
  );

  typedef struct {
    logic [2:0] c;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;   // {negative, zero, overflow, carry_out}
  } vec_t;

  vec_t vecs [11] = '{
    '{3'b010, 8'h7F, 8'h01, 8'h80, 4'b1010},
    '{3'b011, 8'h05, 8'h05, 8'h00, 4'b0101},
    '{3'b011, 8'h00, 8'h01, 8'hFF, 4'b1000},
    '{3'b100, 8'hCC, 8'hAA, 8'h88, 4'b1000},
    '{3'b101, 8'hCC, 8'hAA, 8'hEE, 4'b1000},
    '{3'b110, 8'hCC, 8'hAA, 8'h66, 4'b0000},
    '{3'b000, 8'hCC, 8'hAA, 8'hAA, 4'b1000},
    '{3'b001, 8'hCC, 8'hAA, 8'h00, 4'b0100},
    '{3'b111, 8'hCC, 8'hAA, 8'h00, 4'b0100},
    '{3'b010, 8'h80, 8'h80, 8'h00, 4'b0111},
    '{3'b011, 8'h80, 8'h01, 8'h7F, 4'b0011}
  };

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags8();
    return {b8.negative, b8.zero, b8.overflow, b8.carry_out};
  endfunction

  function automatic logic [3:0] flags64();
    return {b64.negative, b64.zero, b64.overflow, b64.carry_out};
  endfunction

  task automatic issue8(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    b8.control = c; b8.input_A = a; b8.input_B = b; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
  endtask

  task automatic issue64(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    b64.control = c; b64.input_A = a; b64.input_B = b; b64.in_valid = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen, bounded
  task automatic wait8(output int lat);
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic wait64(output int lat);
    lat = 0;
    while (b64.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume8();
    @(negedge clk); b8.out_ready = 1'b1;
    @(posedge clk); #1; b8.out_ready = 1'b0;
  endtask

  task automatic consume64();
    @(negedge clk); b64.out_ready = 1'b1;
    @(posedge clk); #1; b64.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int busy;
    bit first_done;

    reset_n = 1'b0;
    b8.in_valid = 1'b0;  b8.out_ready = 1'b0;  b8.control = '0;
    b8.input_A = '0;     b8.input_B = '0;
    b64.in_valid = 1'b0; b64.out_ready = 1'b0; b64.control = '0;
    b64.input_A = '0;    b64.input_B = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready8", 64'(b8.in_ready), 64'd1);
    check_eq("rst_out_valid8", 64'(b8.out_valid), 64'd0);
    check_eq("rst_result8", 64'(b8.result), 64'd0);
    check_eq("rst_flags8", 64'(flags8()), 64'd0);
    check_eq("rst_in_ready64", 64'(b64.in_ready), 64'd1);
    check_eq("rst_result64", b64.result, 64'd0);
    check_eq("rst_flags64", 64'(flags64()), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_ready8", 64'(b8.in_ready), 64'd1);
    check_eq("idle_out_valid8", 64'(b8.out_valid), 64'd0);

    // Directed 8-bit vectors
    foreach (vecs[i]) begin
      issue8(vecs[i].c, vecs[i].a, vecs[i].b);
      wait8(lat);
      check_eq($sformatf("lat8_%0d", i), 64'(lat), 64'd8);
      check_eq($sformatf("res8_%0d", i), 64'(b8.result), 64'(vecs[i].r));
      check_eq($sformatf("flags8_%0d", i), 64'(flags8()), 64'(vecs[i].f));
      consume8();
      check_eq($sformatf("ready_after8_%0d", i), 64'(b8.in_ready), 64'd1);
    end

    // Reset in the middle of RUN aborts the operation
    issue8(3'b010, 8'h10, 8'h20);
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 64'(b8.out_valid), 64'd0);
    check_eq("abort_in_ready", 64'(b8.in_ready), 64'd1);
    check_eq("abort_result", 64'(b8.result), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (b8.out_valid === 1'b1) seen++;
    end
    check_eq("abort_no_valid", 64'(seen), 64'd0);
    issue8(3'b010, 8'h22, 8'h33);
    wait8(lat);
    check_eq("post_abort_lat", 64'(lat), 64'd8);
    check_eq("post_abort_res", 64'(b8.result), 64'h55);
    check_eq("post_abort_flags", 64'(flags8()), 64'd0);
    consume8();

    // 64-bit, 4-bit slices
    issue64(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait64(lat);
    check_eq("lat64_add", 64'(lat), 64'd16);
    check_eq("res64_add", b64.result, 64'd0);
    check_eq("flags64_add", 64'(flags64()), 64'b0101);
    consume64();
    issue64(3'b011, 64'h8000_0000_0000_0000, 64'd1);
    wait64(lat);
    check_eq("lat64_sub", 64'(lat), 64'd16);
    check_eq("res64_sub", b64.result, 64'h7FFF_FFFF_FFFF_FFFF);
    check_eq("flags64_sub", 64'(flags64()), 64'b0011);
    consume64();

    // Backpressure: result held, pending in_valid not taken until handshake
    issue8(3'b110, 8'hCC, 8'hAA);
    wait8(lat);
    check_eq("bp_lat", 64'(lat), 64'd8);
    @(negedge clk);
    b8.control = 3'b010; b8.input_A = 8'h01; b8.input_B = 8'h02; b8.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("bp_hold_res_%0d", k), 64'(b8.result), 64'h66);
      check_eq($sformatf("bp_hold_ready_%0d", k), 64'(b8.in_ready), 64'd0);
      check_eq($sformatf("bp_hold_valid_%0d", k), 64'(b8.out_valid), 64'd1);
    end
    @(negedge clk); b8.out_ready = 1'b1;
    @(posedge clk); #1; b8.out_ready = 1'b0;
    check_eq("bp_ready_after_hs", 64'(b8.in_ready), 64'd1);
    check_eq("bp_valid_after_hs", 64'(b8.out_valid), 64'd0);
    @(posedge clk); #1; b8.in_valid = 1'b0;
    check_eq("bp_second_accepted", 64'(b8.in_ready), 64'd0);
    wait8(lat);
    check_eq("bp_second_lat", 64'(lat), 64'd8);
    check_eq("bp_second_res", 64'(b8.result), 64'h03);
    consume8();

    // Back-to-back with out_ready held high
    @(negedge clk);
    b8.control = 3'b011; b8.input_A = 8'h10; b8.input_B = 8'h01;
    b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    @(posedge clk); #1;
    busy = 0;
    first_done = 1'b0;
    while (b8.in_ready === 1'b0 && busy < 50) begin
      busy++;
      if (b8.out_valid === 1'b1 && !first_done) begin
        first_done = 1'b1;
        check_eq("b2b_first_res", 64'(b8.result), 64'h0F);
        check_eq("b2b_first_flags", 64'(flags8()), 64'b0001);
      end
      @(posedge clk); #1;
    end
    check_eq("b2b_first_seen", 64'(first_done), 64'd1);
    check_eq("b2b_busy_cycles", 64'(busy), 64'd9);
    b8.control = 3'b101; b8.input_A = 8'h0F; b8.input_B = 8'hF0;
    @(posedge clk); #1; b8.in_valid = 1'b0;
    check_eq("b2b_second_accepted", 64'(b8.in_ready), 64'd0);
    wait8(lat);
    check_eq("b2b_second_lat", 64'(lat), 64'd8);
    check_eq("b2b_second_res", 64'(b8.result), 64'hFF);
    check_eq("b2b_second_flags", 64'(flags8()), 64'b1000);
    @(posedge clk); #1; b8.out_ready = 1'b0;
    check_eq("b2b_ready_end", 64'(b8.in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
